// File: rtl/serial_twoscomp.sv
// Bit-serial two's complement converter. An operand is captured on start and
// then processed LSB first, one bit per cycle. Negation uses the copy-until-
// first-one rule: bits up to and including the first set bit pass unchanged,
// and every later bit is inverted. The finished result is also assembled in
// parallel on out.
module serial_twoscomp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             complement,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);
    // Most negative value: only the sign bit set.
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] d_q;
    logic             comp_q;
    logic [CW-1:0]    cnt_q;
    logic             seen_q;
    logic [WIDTH-1:0] out_q;
    logic             done_q;
    logic             ovf_q;
    logic             cur_bit;
    logic             res_bit;

    // Result bit for the current SHIFT cycle, derived from registered state only.
    always_comb begin
        cur_bit = d_q[cnt_q];
        res_bit = cur_bit ^ (comp_q & seen_q);
    end

    // Conversion FSM together with its datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            d_q     <= '0;
            comp_q  <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    if (start) begin
                        state_q <= StShift;
                        d_q     <= d;
                        comp_q  <= complement;
                        cnt_q   <= '0;
                        seen_q  <= 1'b0;
                        out_q   <= '0;
                    end
                end
                StShift: begin
                    out_q[cnt_q] <= res_bit;
                    seen_q       <= seen_q | cur_bit;
                    if (cnt_q == LastBit) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        ovf_q   <= comp_q && (d_q == MinNeg);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // start is deliberately ignored here.
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy       = (state_q == StShift) || (state_q == StDone);
        sout_valid = (state_q == StShift);
        sout       = (state_q == StShift) ? res_bit : 1'b0;
        done       = done_q;
        out        = out_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_serial_twoscomp.sv
// Directed bench for serial_twoscomp at WIDTH=8: a vector table of conversions
// plus hand-written sequences for busy lockout, reset priority and abort.
module tb_serial_twoscomp;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] d;
    logic       complement;
    logic       busy;
    logic       sout;
    logic       sout_valid;
    logic       done;
    logic [7:0] out;
    logic       overflow;

    int total;
    int bad;

    serial_twoscomp #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .d          (d),
        .complement (complement),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .out        (out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [7:0] eo;
        logic       eov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the cycle after DONE.
    task automatic convert(input logic [7:0] vd, input logic vc, input logic [7:0] eo,
                           input logic eov, input string nm);
        logic [7:0] ser;
        logic       vld_all;
        logic       busy_all;
        start      = 1'b1;
        d          = vd;
        complement = vc;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        // Scramble inputs after capture; the result must not change.
        d          = ~vd;
        complement = ~vc;
        ser      = '0;
        vld_all  = 1'b1;
        busy_all = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ser[k]   = sout;
            vld_all  = vld_all & sout_valid & ~done;
            busy_all = busy_all & busy;
            if (k == 3) start = 1'b1;  // ignored while busy
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check({nm, " sout_seq"}, 32'(ser), 32'(eo));
        check({nm, " valid_busy"}, 32'({vld_all, busy_all}), 32'h3);
        check({nm, " done"}, 32'({done, busy, sout_valid, sout}), 32'hC);
        check({nm, " out"}, 32'(out), 32'(eo));
        check({nm, " ovf"}, 32'(overflow), 32'(eov));
        @(posedge clk);
        @(negedge clk);
        check({nm, " idle"}, 32'({busy, done, overflow, sout_valid, sout}), 32'h0);
        check({nm, " hold"}, 32'(out), 32'(eo));
    endtask

    initial begin
        logic       prev_v;
        int         acc[$];
        logic [7:0] out9;
        logic       any_done;

        total = 0;
        bad   = 0;

        vecs[0] = '{d: 8'h05, c: 1'b1, eo: 8'hFB, eov: 1'b0};
        vecs[1] = '{d: 8'hA5, c: 1'b0, eo: 8'hA5, eov: 1'b0};
        vecs[2] = '{d: 8'h00, c: 1'b1, eo: 8'h00, eov: 1'b0};
        vecs[3] = '{d: 8'h80, c: 1'b1, eo: 8'h80, eov: 1'b1};
        vecs[4] = '{d: 8'h01, c: 1'b1, eo: 8'hFF, eov: 1'b0};
        vecs[5] = '{d: 8'hFF, c: 1'b1, eo: 8'h01, eov: 1'b0};
        vecs[6] = '{d: 8'h7F, c: 1'b1, eo: 8'h81, eov: 1'b0};
        vecs[7] = '{d: 8'h3C, c: 1'b1, eo: 8'hC4, eov: 1'b0};
        vecs[8] = '{d: 8'h80, c: 1'b0, eo: 8'h80, eov: 1'b0};
        vecs[9] = '{d: 8'h5A, c: 1'b1, eo: 8'hA6, eov: 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        d          = 8'h00;
        complement = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({busy, sout, sout_valid, done, overflow, out}), 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            convert(vecs[i].d, vecs[i].c, vecs[i].eo, vecs[i].eov, $sformatf("vec%0d", i));
        end

        // Reset wins over start on the same edge.
        reset = 1'b1;
        start = 1'b1;
        d     = 8'h05;
        complement = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_prio", 32'({busy, sout_valid, out}), 32'h0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_prio_idle", 32'(busy), 32'h0);

        // Busy lockout: start held high; accepts at edges 0, 10, 20.
        start      = 1'b1;
        d          = 8'h05;
        complement = 1'b1;
        prev_v     = 1'b0;
        out9       = '0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sout_valid && !prev_v) acc.push_back(c);
            prev_v = sout_valid;
            if (c == 9) out9 = out;
            if (c < 9) d = 8'(c * 37);
        end
        start = 1'b0;
        check("lock_count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("lock_acc0", 32'(acc[0]), 32'd1);
            check("lock_acc1", 32'(acc[1]), 32'd11);
            check("lock_acc2", 32'(acc[2]), 32'd21);
        end
        check("lock_out", 32'(out9), 32'hFB);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("lock_drained", 32'(busy), 32'h0);

        // Abort: reset during SHIFT cycle 4 of 3C/negate.
        start      = 1'b1;
        d          = 8'h3C;
        complement = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_pre", 32'({busy, sout_valid}), 32'h3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_zero", 32'({busy, sout, sout_valid, done, overflow, out}), 32'h0);
        any_done = 1'b0;
        reset = 1'b0;
        convert(8'h3C, 1'b1, 8'hC4, 1'b0, "after_abort");
        any_done = done;
        check("abort_no_stray_done", 32'(any_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
